dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving load/store requests from the pipeline's memory stage. Holds a word-addressed RAM, inserts a programmable number of wait states per access and drives a combinational stall that the top level folds into the global pipeline stall. It is the memory-side end of the memory stage's load/store interface, replacing the current zero-latency, never-stalling data path.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4 to 65536.
- WAIT_STATES, 2, extra cycles per access; 0 to 15.

- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request valid; held with we/addr/wdata until ready.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data.
- rdata  output  32  load data, registered; valid while ready is high after a load.
- ready  output  1  one-cycle completion pulse.
- stall  output  1  combinational: req && !ready.
- perr  output  1  parity error on the completing load (see Configuration).

## Operation
- Word index = addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] and upper bits are ignored, so upper bits alias.
- FSM states:
  - IDLE, ready=0. On req=1: latch we, index and wdata; load a 4-bit counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else DONE.
  - WAIT. When the counter is 1, go to DONE; otherwise decrement the counter.
  - DONE, ready=1. Unconditionally return to IDLE. req is ignored in DONE.
- Commit happens on the edge that enters DONE.
  - Store: RAM[index] <= latched wdata. rdata is unchanged.
  - Load: rdata <= RAM[index].
- Only latched values are used after acceptance. Changing or dropping req during WAIT is a protocol violation; the latched transaction still completes.
- The RAM array is not reset. Loads from never-written words return X in simulation.
- Reset (reset=0, at any time):
  - state <= IDLE, counter <= 0; a pending store is discarded and the RAM is untouched.
  - Outputs: rdata=0, ready=0, perr=0. stall still follows req.

## Timing
- A request is accepted on the edge where state is IDLE and req=1 (edge 0).
- ready is high in cycle WAIT_STATES+1 after acceptance, for exactly one cycle.
- stall is high from the cycle req rises through the last WAIT cycle, and low in the DONE cycle.
- Back-to-back: the next request can be accepted one cycle after DONE, in IDLE. Minimum spacing is WAIT_STATES+2 cycles per access.
- A store immediately followed by a load to the same word returns the new data; no bypass is needed because the commit precedes the next acceptance.

## Configuration
- DMEM_PARITY_EN defined:
  - Each word stores one extra even-parity bit, computed from wdata on store.
  - On a load, parity is recomputed over the stored data. perr is registered alongside rdata and is high in the DONE cycle on mismatch.
  - perr is 0 on stores.
- DMEM_PARITY_EN undefined: no parity storage; perr is tied to 0.

## Test plan
- Reset: hold reset=0 with req=0, then release. Required: ready=0, rdata=0x00000000, perr=0, stall=0. Then drive req=1 with reset low: stall=1 and state stays IDLE.
- WAIT_STATES=2: store 0xDEADBEEF to 0x40, then load 0x40. Required: ready high exactly in cycle 3 after each acceptance, stall high in cycles 0–2, load rdata=0xDEADBEEF.
- Aliasing, DEPTH_WORDS=256: store 0x11111111 to 0x000, then 0x22222222 to 0x400. Required: load 0x003 returns 0x22222222.
- Reset mid-operation: store 0xAAAA5555 to 0x10. Start a store of 0x12345678 to 0x10 and pulse reset low during WAIT. Required: ready never pulses for that store; a subsequent load of 0x10 returns 0xAAAA5555.
- WAIT_STATES=0, back-to-back loads: each ready arrives 1 cycle after acceptance and stall is high for 1 cycle. A req held high through DONE is not re-accepted until the following IDLE cycle.
- DMEM_PARITY_EN defined: store 0x0000000F, flip stored data bit 0 by hierarchical deposit, then load. Required: rdata=0x0000000E and perr=1 in the ready cycle. Repeat without the flip: perr=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the memory stage's load/store port. Holds a
//   word-addressed RAM, inserts WAIT_STATES wait cycles per access and drives
//   a combinational stall into the global pipeline stall.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 4..65536)
//   WAIT_STATES  extra cycles per access (0..15)
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-low reset
//   req    in   request valid, held with we/addr/wdata until ready
//   we     in   1 = store, 0 = load
//   addr   in   byte address; word index = addr[log2(DEPTH_WORDS)+1:2]
//   wdata  in   store data
//   rdata  out  registered load data, valid while ready after a load
//   ready  out  one-cycle completion pulse (DONE state)
//   stall  out  req && !ready
//   perr   out  parity error on the completing load
//
// Optional feature macro: DMEM_PARITY_EN
//   defined   -> one even-parity bit per word, checked on loads, reported on perr
//   undefined -> no parity storage, perr tied low
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        stall,
   output logic        perr
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

   typedef struct packed {
      logic             we;
      logic [IDX_W-1:0] idx;
      logic [31:0]      data;
   } xactT;

   stateT      state, nextState;
   logic [3:0] cnt, nextCnt;
   logic       commit;
   xactT       lat, cur;

   logic [31:0] mem [DEPTH_WORDS];

   // Only the index bits select a word; byte offset and upper bits alias.
   logic unusedAddrBits;
   assign unusedAddrBits = &{1'b0, addr[1:0], addr[31:IDX_W+2]};

   // In IDLE the transaction comes straight from the port (needed when
   // WAIT_STATES is 0 and the commit is on the accepting edge); afterwards
   // only the latched copy is used, so req/addr wiggles in WAIT are ignored.
   always_comb begin
      cur = lat;
      if (state == IDLE) begin
         cur.we   = we;
         cur.idx  = addr[IDX_W+1:2];
         cur.data = wdata;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   // Next state, counter and outputs. commit marks the edge entering DONE.
   always_comb begin
      nextState = state;
      nextCnt   = cnt;
      commit    = 1'b0;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               nextCnt = WAIT_CNT;
               if (WAIT_CNT == 4'd0) begin
                  nextState = DONE;
                  commit    = 1'b1;
               end else begin
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               nextState = DONE;
               nextCnt   = 4'd0;
               commit    = 1'b1;
            end else begin
               nextCnt = cnt - 4'd1;
            end
         end
         DONE: begin
            ready     = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   assign stall = req && !ready;

   // Transaction latch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         lat <= '0;
      else if (state == IDLE && req)
         lat <= cur;
   end

   // RAM is never reset. reset gates the write so that a store whose commit
   // edge falls inside reset is dropped.
   always_ff @(posedge clk) begin
      if (commit && reset && cur.we)
         mem[cur.idx] <= cur.data;
   end

   // Load data register; stores leave rdata untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rdata <= '0;
      else if (commit && !cur.we)
         rdata <= mem[cur.idx];
   end

`ifdef DMEM_PARITY_EN
   logic memPar [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (commit && reset && cur.we)
         memPar[cur.idx] <= ^cur.data;
   end

   // Parity is recomputed over the stored word, so corruption of the data
   // bits after the store shows up as a mismatch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         perr <= 1'b0;
      else if (commit)
         perr <= cur.we ? 1'b0 : ((^mem[cur.idx]) != memPar[cur.idx]);
   end
`else
   assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        ready, stall, perr;

   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [31:0] rdata0;
   logic        ready0, stall0, perr0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .stall(stall), .perr(perr)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .ready(ready0), .stall(stall0), .perr(perr0)
   );

   // Drives one access on dut for a fixed 8-cycle window. Cycle 0 is the
   // cycle req is first high (accepted on the edge ending it). req drops on
   // the edge after ready is seen. Returns observations only.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int rc, output int rn, output logic [7:0] sm,
                         output logic [31:0] rd, output logic pe);
      rc = -1; rn = 0; sm = '0; rd = 'x; pe = 1'bx;
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         sm[c] = stall;
         if (ready) begin
            rn++;
            if (rc < 0) begin
               rc = c; rd = rdata; pe = perr;
            end
         end
         @(posedge clk); #1;
         if (rc >= 0) req = 1'b0;
      end
      req = 1'b0;
   endtask

   task automatic test_reset();
      int rn;
      req = 1'b0; req0 = 1'b0; reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
      total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", perr); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      @(posedge clk); #1;
      req = 1'b1; req0 = 1'b1;
      @(negedge clk);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_req: got %b want 1", stall); end
      total++; if (stall0 !== 1'b1) begin bad++; $display("FAIL reset_stall0_req: got %b want 1", stall0); end
      rn = 0;
      repeat (4) begin @(negedge clk); if (ready || ready0) rn++; end
      total++; if (rn !== 0) begin bad++; $display("FAIL reset_held_idle: got %0d ready cycles want 0", rn); end
      @(posedge clk); #1;
      req = 1'b0; req0 = 1'b0; reset = 1'b1;
      rn = 0;
      repeat (3) begin @(negedge clk); if (ready || ready0) rn++; end
      total++; if (rn !== 0) begin bad++; $display("FAIL reset_release_idle: got %0d ready cycles want 0", rn); end
   endtask

   task automatic test_store_load();
      int rc, rn; logic [7:0] sm; logic [31:0] rd; logic pe;
      access(1'b1, 32'h40, 32'hDEADBEEF, rc, rn, sm, rd, pe);
      total++; if (rc !== 3) begin bad++; $display("FAIL st_ready_cycle: got %0d want 3", rc); end
      total++; if (rn !== 1) begin bad++; $display("FAIL st_ready_count: got %0d want 1", rn); end
      total++; if (sm !== 8'b0000_0111) begin bad++; $display("FAIL st_stall_mask: got %b want 00000111", sm); end
      total++; if (pe !== 1'b0) begin bad++; $display("FAIL st_perr: got %b want 0", pe); end
      access(1'b0, 32'h40, 32'h0, rc, rn, sm, rd, pe);
      total++; if (rc !== 3) begin bad++; $display("FAIL ld_ready_cycle: got %0d want 3", rc); end
      total++; if (rn !== 1) begin bad++; $display("FAIL ld_ready_count: got %0d want 1", rn); end
      total++; if (sm !== 8'b0000_0111) begin bad++; $display("FAIL ld_stall_mask: got %b want 00000111", sm); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata: got %h want deadbeef", rd); end
      total++; if (pe !== 1'b0) begin bad++; $display("FAIL ld_perr: got %b want 0", pe); end
   endtask

   task automatic test_alias();
      int rc, rn; logic [7:0] sm; logic [31:0] rd; logic pe;
      access(1'b1, 32'h000, 32'h11111111, rc, rn, sm, rd, pe);
      access(1'b1, 32'h400, 32'h22222222, rc, rn, sm, rd, pe);
      access(1'b0, 32'h003, 32'h0, rc, rn, sm, rd, pe);
      total++; if (rd !== 32'h22222222) begin bad++; $display("FAIL alias_rdata: got %h want 22222222", rd); end
   endtask

   task automatic test_reset_mid();
      int rc, rn; logic [7:0] sm; logic [31:0] rd; logic pe;
      access(1'b1, 32'h10, 32'hAAAA5555, rc, rn, sm, rd, pe);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h12345678;
      @(posedge clk); #1;          // accepted, now in WAIT
      reset = 1'b0; req = 1'b0;
      @(negedge clk);
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL mid_reset_rdata: got %h want 00000000", rdata); end
      @(posedge clk); #1;
      reset = 1'b1;
      rn = 0;
      repeat (5) begin @(negedge clk); if (ready) rn++; end
      total++; if (rn !== 0) begin bad++; $display("FAIL mid_reset_ready: got %0d pulses want 0", rn); end
      access(1'b0, 32'h10, 32'h0, rc, rn, sm, rd, pe);
      total++; if (rd !== 32'hAAAA5555) begin bad++; $display("FAIL mid_reset_ram: got %h want aaaa5555", rd); end
      total++; if (rc !== 3) begin bad++; $display("FAIL mid_reset_recover: got %0d want 3", rc); end
   endtask

   // WAIT_STATES=0: store then loads with req held high throughout.
   // Expected: IDLE/DONE alternate, so ready in odd cycles, stall in even.
   task automatic test_back_to_back();
      logic [5:0]  rm, sm;
      logic [31:0] rd3, rd5;
      rm = '0; sm = '0; rd3 = '0; rd5 = '0;
      @(posedge clk); #1;
      for (int c = 0; c < 6; c++) begin
         if (c == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'hCAFEF00D; end
         if (c == 2) we0 = 1'b0;
         @(negedge clk);
         rm[c] = ready0; sm[c] = stall0;
         if (c == 3) rd3 = rdata0;
         if (c == 5) rd5 = rdata0;
         @(posedge clk); #1;
      end
      req0 = 1'b0;
      total++; if (rm !== 6'b101010) begin bad++; $display("FAIL b2b_ready_mask: got %b want 101010", rm); end
      total++; if (sm !== 6'b010101) begin bad++; $display("FAIL b2b_stall_mask: got %b want 010101", sm); end
      total++; if (rd3 !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_load1: got %h want cafef00d", rd3); end
      total++; if (rd5 !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_load2: got %h want cafef00d", rd5); end
   endtask

`ifdef DMEM_PARITY_EN
   task automatic test_parity();
      int rc, rn; logic [7:0] sm; logic [31:0] rd; logic pe;
      access(1'b1, 32'h20, 32'h0000000F, rc, rn, sm, rd, pe);
      dut.mem[8] = dut.mem[8] ^ 32'h1;
      access(1'b0, 32'h20, 32'h0, rc, rn, sm, rd, pe);
      total++; if (rd !== 32'h0000000E) begin bad++; $display("FAIL par_rdata: got %h want 0000000e", rd); end
      total++; if (pe !== 1'b1) begin bad++; $display("FAIL par_perr_flip: got %b want 1", pe); end
      access(1'b1, 32'h20, 32'h0000000F, rc, rn, sm, rd, pe);
      access(1'b0, 32'h20, 32'h0, rc, rn, sm, rd, pe);
      total++; if (rd !== 32'h0000000F) begin bad++; $display("FAIL par_rdata_clean: got %h want 0000000f", rd); end
      total++; if (pe !== 1'b0) begin bad++; $display("FAIL par_perr_clean: got %b want 0", pe); end
   endtask
`endif

   initial begin
      test_reset();
      test_store_load();
      test_alias();
      test_reset_mid();
      test_back_to_back();
`ifdef DMEM_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
